// File: rtl/vga_pattern_ctrl.sv
// VGA timing generator with four built-in test patterns.
// Every output is registered once from the (h,v) raster position, so all outputs share one cycle of latency.
module vga_pattern_ctrl #(
  parameter int G_H_RES  = 640,
  parameter int G_V_RES  = 480,
  parameter int G_H_FP   = 16,
  parameter int G_H_SYNC = 96,
  parameter int G_H_BP   = 48,
  parameter int G_V_FP   = 10,
  parameter int G_V_SYNC = 2,
  parameter int G_V_BP   = 33,
  parameter int G_H_POL  = 0,
  parameter int G_V_POL  = 0,
  parameter int G_CW     = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_mode,
  output logic            o_h_sync,
  output logic            o_v_sync,
  output logic [G_CW-1:0] o_r,
  output logic [G_CW-1:0] o_g,
  output logic [G_CW-1:0] o_b,
  output logic            o_active,
  output logic [11:0]     o_x,
  output logic [11:0]     o_y,
  output logic            o_frame_start,
  output logic [7:0]      o_frame_cnt
);

  localparam int H_TOT = G_H_RES + G_H_FP + G_H_SYNC + G_H_BP;
  localparam int V_TOT = G_V_RES + G_V_FP + G_V_SYNC + G_V_BP;
  localparam int BAR_W = G_H_RES / 8;

  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
  localparam logic [12:0] H_ACT    = 13'(G_H_RES);
  localparam logic [12:0] V_ACT    = 13'(G_V_RES);
  localparam logic [12:0] H_SS     = 13'(G_H_RES + G_H_FP);
  localparam logic [12:0] H_SE     = 13'(G_H_RES + G_H_FP + G_H_SYNC);
  localparam logic [12:0] V_SS     = 13'(G_V_RES + G_V_FP);
  localparam logic [12:0] V_SE     = 13'(G_V_RES + G_V_FP + G_V_SYNC);
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
  localparam logic        H_POL    = 1'(G_H_POL);
  localparam logic        V_POL    = 1'(G_V_POL);
  localparam logic [G_CW-1:0] ONES = {G_CW{1'b1}};

  if (H_TOT > 4096 || V_TOT > 4096) begin : g_bad_total
    $error("vga_pattern_ctrl: H_TOT and V_TOT must not exceed 4096");
  end
  if (G_H_RES < 8 || (G_H_RES % 8) != 0) begin : g_bad_hres
    $error("vga_pattern_ctrl: G_H_RES must be a non-zero multiple of 8");
  end
  if (G_CW < 1 || G_CW > 8) begin : g_bad_cw
    $error("vga_pattern_ctrl: G_CW must be in 1..8");
  end

  logic [11:0]     h, v, h_nxt, v_nxt;
  logic [11:0]     bar_px;
  logic [2:0]      bar_idx;
  logic [1:0]      r_mode;
  logic            first_frame;
  logic            h_last, v_last, h_vis, active, hs_on, vs_on, at_origin;
  logic [7:0]      cnt_nxt;
  logic [G_CW-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    h_last    = (h == H_LAST);
    v_last    = (v == V_LAST);
    h_nxt     = h_last ? 12'd0 : h + 12'd1;
    v_nxt     = v;
    if (h_last) v_nxt = v_last ? 12'd0 : v + 12'd1;
    h_vis     = ({1'b0, h} < H_ACT);
    active    = h_vis && ({1'b0, v} < V_ACT);
    hs_on     = ({1'b0, h} >= H_SS) && ({1'b0, h} < H_SE);
    vs_on     = ({1'b0, v} >= V_SS) && ({1'b0, v} < V_SE);
    at_origin = (h == 12'd0) && (v == 12'd0);
    // The first frame after reset keeps count 0; later frames advance on (0,0).
    cnt_nxt   = (at_origin && !first_frame) ? o_frame_cnt + 8'd1 : o_frame_cnt;

    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (r_mode)
      2'd0: begin
        pix_r = {G_CW{~bar_idx[2]}};
        pix_g = {G_CW{~bar_idx[1]}};
        pix_b = {G_CW{~bar_idx[0]}};
      end
      2'd1: begin
        if (h[3] ^ v[3]) begin
          pix_r = ONES;
          pix_g = ONES;
          pix_b = ONES;
        end
      end
      2'd2: begin
        pix_r = h[G_CW+3:4];
        pix_g = h[G_CW+3:4];
        pix_b = h[G_CW+3:4];
      end
      default: begin
        if (h[9:4] == cnt_nxt[5:0]) begin
          pix_r = ONES;
          pix_g = ONES;
          pix_b = ONES;
        end
      end
    endcase
    if (!active) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h             <= '0;
      v             <= '0;
      bar_px        <= '0;
      bar_idx       <= '0;
      r_mode        <= '0;
      first_frame   <= 1'b1;
      o_h_sync      <= ~H_POL;
      o_v_sync      <= ~V_POL;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_active      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      h <= h_nxt;
      v <= v_nxt;
      // Bar index tracks h by counting pixels within the bar, avoiding a divider.
      if (h_last) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (h_vis) begin
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 12'd1;
        end
      end
      if (h_last && v_last) r_mode <= i_mode;
      if (at_origin) first_frame <= 1'b0;
      o_h_sync      <= hs_on ? H_POL : ~H_POL;
      o_v_sync      <= vs_on ? V_POL : ~V_POL;
      o_r           <= pix_r;
      o_g           <= pix_g;
      o_b           <= pix_b;
      o_active      <= active;
      o_x           <= h;
      o_y           <= v;
      o_frame_start <= at_origin;
      o_frame_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: doc/vga_pattern_ctrl.md
VGA_PATTERN_CTRL -- requirements
Module: vga_pattern_ctrl

Interface
REQ-001 SHALL have parameter G_H_RES, default 640: active pixels per line.
REQ-002 SHALL have parameter G_V_RES, default 480: active lines per frame.
REQ-003 SHALL have parameters G_H_FP/G_H_SYNC/G_H_BP, defaults 16/96/48: horizontal front porch/sync/back porch, in pixels.
REQ-004 SHALL have parameters G_V_FP/G_V_SYNC/G_V_BP, defaults 10/2/33: vertical front porch/sync/back porch, in lines.
REQ-005 SHALL have parameters G_H_POL and G_V_POL, default 0: sync active level (0 = active-low).
REQ-006 SHALL have parameter G_CW, default 4: bits per colour channel, legal range 1..8.
REQ-007 SHALL have port i_clk, input, 1 bit: pixel clock; one clock and reset is asynchronous and active-high.
REQ-008 SHALL have port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-009 SHALL have port i_mode, input, 2 bits: requested pattern mode.
REQ-010 SHALL have ports o_h_sync and o_v_sync, output, 1 bit each: sync outputs at the configured polarity.
REQ-011 SHALL have ports o_r, o_g and o_b, output, G_CW bits each: colour channels.
REQ-012 SHALL have port o_active, output, 1 bit: the pixel is in the visible area.
REQ-013 SHALL have ports o_x and o_y, output, 12 bits each: current pixel coordinates.
REQ-014 SHALL have port o_frame_start, output, 1 bit: one-cycle pulse at pixel (0,0).
REQ-015 SHALL have port o_frame_cnt, output, 8 bits: frame counter.

Function
REQ-016 SHALL define H_TOT = G_H_RES+G_H_FP+G_H_SYNC+G_H_BP and V_TOT = G_V_RES+G_V_FP+G_V_SYNC+G_V_BP; both SHALL be at most 4096, and G_H_RES SHALL be divisible by 8 (elaboration check).
REQ-017 SHALL run horizontal counter h over 0..H_TOT-1, incrementing every cycle and wrapping to 0.
REQ-018 SHALL increment vertical counter v only when h wraps, over 0..V_TOT-1, wrapping to 0.
REQ-019 SHALL register every output once from (h,v), giving a fixed latency of 1 cycle with all outputs mutually aligned.
REQ-020 SHALL drive o_active = 1 iff h < G_H_RES and v < G_V_RES.
REQ-021 SHALL drive o_x = h and o_y = v.
REQ-022 SHALL assert o_h_sync (level G_H_POL) iff G_H_RES+G_H_FP <= h < G_H_RES+G_H_FP+G_H_SYNC, and drive it to ~G_H_POL otherwise.
REQ-023 SHALL assert o_v_sync (level G_V_POL) iff G_V_RES+G_V_FP <= v < G_V_RES+G_V_FP+G_V_SYNC, and drive it to ~G_V_POL otherwise.
REQ-024 SHALL latch i_mode into internal r_mode only on the cycle (h,v) = (H_TOT-1, V_TOT-1); i_mode changes mid-frame SHALL have no effect until the next frame.
REQ-025 SHALL drive o_r/o_g/o_b to 0 whenever o_active = 0.
REQ-026 SHALL, in mode 0 (colour bars), keep bar index i (0..7) incremented every G_H_RES/8 active pixels with no divider, reset to 0 at h = 0, and drive each channel all-ones or all-zeros as r = ~i[2], g = ~i[1], b = ~i[0] (bar 0 white, bar 7 black).
REQ-027 SHALL, in mode 1 (checkerboard), drive all channels all-ones when h[3] XOR v[3] = 1, else 0.
REQ-028 SHALL, in mode 2 (gradient), drive r = g = b = bits [G_CW+3:4] of h, zero-extended if h is narrower.
REQ-029 SHALL, in mode 3 (moving bar), drive all channels all-ones when h[9:4] = o_frame_cnt[5:0], else 0.
REQ-030 SHALL increment o_frame_cnt by 1 (wrapping 255 -> 0) in the same output cycle that o_frame_start = 1, except for the first frame after reset, which SHALL have o_frame_cnt = 0.
REQ-031 SHALL drive o_frame_start = 1 exactly in the output cycle for (h,v) = (0,0), including the first frame after reset.

Reset
REQ-032 SHALL, while i_rst = 1, clear h, v, bar index, r_mode and the frame counter to 0.
REQ-033 SHALL, while i_rst = 1, drive o_r/o_g/o_b/o_x/o_y/o_active/o_frame_start/o_frame_cnt to 0, o_h_sync to ~G_H_POL and o_v_sync to ~G_V_POL.
REQ-034 SHALL, on reset assertion mid-frame, reach the REQ-032/REQ-033 values immediately without waiting for a clock edge.
REQ-035 SHALL, on the first edge after reset release, output pixel (0,0) with o_frame_start = 1 and o_frame_cnt = 0, using mode 0.

Verification
REQ-036 SHALL check, with defaults after reset: o_h_sync low for exactly output cycles x = 656..751, with a period of 800 cycles.
REQ-037 SHALL check, with defaults: o_v_sync low for lines y = 490..491, with a frame of 420000 cycles, and o_frame_start pulses exactly 420000 cycles apart.
REQ-038 SHALL check mode 0 at y = 0: x = 0 gives all channels 0xF; x = 80 gives (0xF, 0xF, 0x0); x = 639 gives 0; x = 640 gives 0 with o_active = 0.
REQ-039 SHALL check i_mode driven 0 -> 1 at pixel (100,100): the remainder of the frame stays colour bars, and the next frame shows (0,8) white and (0,0) black.
REQ-040 SHALL check i_rst asserted at (300,200) for 3 cycles: outputs reach reset values asynchronously; after release, (0,0) appears with o_frame_start = 1 and o_frame_cnt = 0.
REQ-041 SHALL check G_H_POL = 1, G_CW = 2: o_h_sync is high only during sync, mode 2 at x = 48 outputs 0b11, and o_frame_cnt wraps 255 -> 0 after 256 frames.
